// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per BUSY cycle, valid/ready on both sides.
// Define SEQ_DIVIDER_EARLY_EXIT_EN to finish immediately when divisor > dividend.
module seq_divider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [N-1:0]  quo, rem, dvs;
  logic [CW-1:0] cnt;
  logic          dbz;

  // Shifted partial remainder is N+1 bits wide; the subtract runs one bit wider
  // still so its top bit is the carry-out (1 = no borrow).
  logic [N+1:0] sub;
  logic         no_borrow;
  logic         sub_unused;

  assign sub        = {1'b0, rem, quo[N-1]} + {1'b0, ~{1'b0, dvs}} + (N+2)'(1);
  assign no_borrow  = sub[N+1];
  assign sub_unused = sub[N];

  assign i_ready     = (state == IDLE);
  assign o_valid     = (state == DONE);
  assign quotient    = quo;
  assign remainder   = rem;
  assign div_by_zero = dbz;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      cnt   <= '0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          if (divisor == '0) begin
            quo   <= '1;
            rem   <= dividend;
            dbz   <= 1'b1;
            state <= DONE;
          end
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
          else if (divisor > dividend) begin
            quo   <= '0;
            rem   <= dividend;
            dbz   <= 1'b0;
            state <= DONE;
          end
`endif
          else begin
            quo   <= dividend;
            rem   <= '0;
            dvs   <= divisor;
            cnt   <= CW'(N-1);
            dbz   <= 1'b0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (no_borrow) rem <= sub[N-1:0];
          else           rem <= {rem[N-2:0], quo[N-1]};
          quo <= {quo[N-2:0], no_borrow};
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= DONE;
        end
        DONE: if (o_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at N=8: latency, results, back-pressure, reset abort.
module tb_seq_divider;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_ready;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         o_valid;
  logic         o_ready = 1'b0;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int failures = 0;
  int lat;
  int exp_lat_small;
  logic [N-1:0] q_hold, r_hold;

  seq_divider #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_ready(i_ready),
    .dividend(dividend), .divisor(divisor),
    .o_valid(o_valid), .o_ready(o_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands, wait for the accept edge, then count edges (accept edge = 1) to o_valid.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, output int l);
    chk("i_ready_before_accept", {31'd0, i_ready}, 32'd1);
    dividend = a;
    divisor  = b;
    i_valid  = 1'b1;
    tick();
    i_valid  = 1'b0;
    dividend = 8'hA5;
    divisor  = 8'h5A;
    l = 1;
    while (!o_valid && l < 40) begin
      tick();
      l++;
    end
  endtask

  task automatic consume();
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
  endtask

  initial begin
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
    exp_lat_small = 1;
`else
    exp_lat_small = N + 1;
`endif
    // Reset state
    #2;
    tick();
    tick();
    chk("rst_i_ready", {31'd0, i_ready}, 32'd1);
    chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_i_ready", {31'd0, i_ready}, 32'd1);

    // 100 / 7
    run_op(8'd100, 8'd7, lat);
    chk("100_7_latency", lat, 32'd9);
    chk("100_7_q", quotient, 32'd14);
    chk("100_7_r", remainder, 32'd2);
    chk("100_7_dbz", {31'd0, div_by_zero}, 32'd0);
    chk("100_7_i_ready_done", {31'd0, i_ready}, 32'd0);
    consume();
    chk("100_7_back_idle", {31'd0, i_ready}, 32'd1);

    // Divisor with MSB set, and divide by one
    run_op(8'd250, 8'd200, lat);
    chk("250_200_q", quotient, 32'd1);
    chk("250_200_r", remainder, 32'd50);
    consume();
    run_op(8'd255, 8'd1, lat);
    chk("255_1_latency", lat, 32'd9);
    chk("255_1_q", quotient, 32'd255);
    chk("255_1_r", remainder, 32'd0);
    consume();
    run_op(8'd255, 8'd128, lat);
    chk("255_128_q", quotient, 32'd1);
    chk("255_128_r", remainder, 32'd127);
    consume();

    // Divide by zero, then a normal op must clear the flag
    run_op(8'd42, 8'd0, lat);
    chk("div0_latency", lat, 32'd1);
    chk("div0_q", quotient, 32'hFF);
    chk("div0_r", remainder, 32'd42);
    chk("div0_dbz", {31'd0, div_by_zero}, 32'd1);
    consume();
    run_op(8'd0, 8'd5, lat);
    chk("0_5_q", quotient, 32'd0);
    chk("0_5_r", remainder, 32'd0);
    chk("0_5_dbz_cleared", {31'd0, div_by_zero}, 32'd0);
    consume();

    // Back-pressure: 200 / 3 held in DONE while new operands are offered
    run_op(8'd200, 8'd3, lat);
    chk("bp_q", quotient, 32'd66);
    chk("bp_r", remainder, 32'd2);
    q_hold = quotient;
    r_hold = remainder;
    dividend = 8'd17;
    divisor  = 8'd0;
    i_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_i_ready_low", {31'd0, i_ready}, 32'd0);
      chk("bp_o_valid_held", {31'd0, o_valid}, 32'd1);
      chk("bp_q_stable", quotient, {24'd0, q_hold});
      chk("bp_r_stable", remainder, {24'd0, r_hold});
      chk("bp_dbz_stable", {31'd0, div_by_zero}, 32'd0);
    end
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
    i_valid = 1'b0;
    chk("bp_consume_idle", {31'd0, i_ready}, 32'd1);
    chk("bp_consume_no_valid", {31'd0, o_valid}, 32'd0);

    // Reset during the third BUSY step
    dividend = 8'd77;
    divisor  = 8'd5;
    i_valid  = 1'b1;
    tick();
    i_valid  = 1'b0;
    tick();
    tick();
    chk("mid_busy", {31'd0, i_ready}, 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_i_ready", {31'd0, i_ready}, 32'd1);
    chk("mid_rst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("mid_rst_q", quotient, 32'd0);
    chk("mid_rst_r", remainder, 32'd0);
    chk("mid_rst_dbz", {31'd0, div_by_zero}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mid_rst_no_valid", {31'd0, o_valid}, 32'd0);
    end
    run_op(8'd9, 8'd3, lat);
    chk("9_3_latency", lat, 32'd9);
    chk("9_3_q", quotient, 32'd3);
    chk("9_3_r", remainder, 32'd0);
    consume();

    // Divisor larger than dividend
    run_op(8'd5, 8'd9, lat);
    chk("5_9_latency", lat, exp_lat_small);
    chk("5_9_q", quotient, 32'd0);
    chk("5_9_r", remainder, 32'd5);
    chk("5_9_dbz", {31'd0, div_by_zero}, 32'd0);
    consume();
    chk("final_idle", {31'd0, i_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
